uart_controller: RTL and testbench

Dual-port UART man-in-the-middle controller. It sits between two UART devices (if0, if1) under the generic bus interface wrapper and below the MITM logic. Each RX line is passed through to the opposite device's TX line by default. Every received frame is also decoded and reported. The MITM logic can take over either TX line to inject its own frames.

---
 rtl/uart_controller_if.sv | 41 ++++
 rtl/uart_controller.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_controller_if.sv
// MITM-facing control bundle for uart_controller: fake TX select/start/data
// and RX decode / TX handshake status for both channels.
// master = MITM logic side, slave = uart_controller side.
interface uart_controller_if #(
    parameter int NUM_DATA_BITS = 8
);
    logic                     fake_if0_tx_select;
    logic                     fake_if1_tx_select;
    logic                     fake_if0_tx_start;
    logic                     fake_if1_tx_start;
    logic [NUM_DATA_BITS-1:0] fake_if0_transmit_data;
    logic [NUM_DATA_BITS-1:0] fake_if1_transmit_data;
    logic                     if0_rx_new_data_ready;
    logic                     if1_rx_new_data_ready;
    logic [NUM_DATA_BITS-1:0] real_if0_receive_data;
    logic [NUM_DATA_BITS-1:0] real_if1_receive_data;
    logic                     if0_tx_write_ready;
    logic                     if1_tx_write_ready;
    logic                     if0_tx_write_done;
    logic                     if1_tx_write_done;

    modport master (
        output fake_if0_tx_select, fake_if1_tx_select,
        output fake_if0_tx_start, fake_if1_tx_start,
        output fake_if0_transmit_data, fake_if1_transmit_data,
        input  if0_rx_new_data_ready, if1_rx_new_data_ready,
        input  real_if0_receive_data, real_if1_receive_data,
        input  if0_tx_write_ready, if1_tx_write_ready,
        input  if0_tx_write_done, if1_tx_write_done
    );

    modport slave (
        input  fake_if0_tx_select, fake_if1_tx_select,
        input  fake_if0_tx_start, fake_if1_tx_start,
        input  fake_if0_transmit_data, fake_if1_transmit_data,
        output if0_rx_new_data_ready, if1_rx_new_data_ready,
        output real_if0_receive_data, real_if1_receive_data,
        output if0_tx_write_ready, if1_tx_write_ready,
        output if0_tx_write_done, if1_tx_write_done
    );
endinterface

// File: rtl/uart_controller.sv
// Dual-port UART MITM controller: RX pass-through to opposite TX, frame
// decode on both RX lines, optional fake-frame injection on either TX.
// Ports: sys_clk, rst (async, active-high), bus (uart_controller_if.slave),
// if0/if1_rx_in serial inputs, if0/if1_tx_out serial outputs.
// Option: define UART_RX_SYNC_EN to put a 2-flop synchronizer on each RX.
module uart_rx #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic                     valid_o,
    output logic [NUM_DATA_BITS-1:0] data_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_DATA_BITS - 1);

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    rx_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic [NUM_DATA_BITS-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            prev_q  <= rx;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[NUM_DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    // bad stop bit: drop the frame silently
                    if (rx) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

module uart_tx #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_DATA_BITS-1:0] data,
    output logic                     ready_o,
    output logic                     done_o,
    output logic                     line_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_DATA_BITS - 1);

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;

    tx_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic                     done_q, done_d;
    logic                     line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        line    = 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    shift_d = data;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                line = 1'b0;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                line = shift_q[0];
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[NUM_DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign ready_o = (state_q == TX_IDLE);
    assign done_o  = done_q;
    assign line_o  = line;
endmodule

module uart_controller #(
    parameter int SYS_FREQ_HZ   = 12_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    uart_controller_if.slave        bus,
    input  logic                    if0_rx_in,
    input  logic                    if1_rx_in,
    output logic                    if0_tx_out,
    output logic                    if1_tx_out
);
    localparam int CLKS_PER_BIT = SYS_FREQ_HZ / BAUD_RATE;

    logic rx0, rx1;
    logic t0_line, t1_line;
    logic t0_ready, t1_ready;
    logic sel0_q, sel0_d;
    logic sel1_q, sel1_d;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync0_q, sync0_d;
    logic [1:0] sync1_q, sync1_d;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync0_q <= 2'b11;
            sync1_q <= 2'b11;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
        end
    end

    always_comb begin
        sync0_d = {sync0_q[0], if0_rx_in};
        sync1_d = {sync1_q[0], if1_rx_in};
    end

    assign rx0 = sync0_q[1];
    assign rx1 = sync1_q[1];
`else
    assign rx0 = if0_rx_in;
    assign rx1 = if1_rx_in;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT), .NUM_DATA_BITS(NUM_DATA_BITS)
    ) u_rx0 (
        .clk(sys_clk), .rst(rst), .rx(rx0),
        .valid_o(bus.if0_rx_new_data_ready),
        .data_o(bus.real_if0_receive_data)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT), .NUM_DATA_BITS(NUM_DATA_BITS)
    ) u_rx1 (
        .clk(sys_clk), .rst(rst), .rx(rx1),
        .valid_o(bus.if1_rx_new_data_ready),
        .data_o(bus.real_if1_receive_data)
    );

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT), .NUM_DATA_BITS(NUM_DATA_BITS)
    ) u_tx0 (
        .clk(sys_clk), .rst(rst),
        .start(bus.fake_if0_tx_start),
        .data(bus.fake_if0_transmit_data),
        .ready_o(t0_ready), .done_o(bus.if0_tx_write_done),
        .line_o(t0_line)
    );

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT), .NUM_DATA_BITS(NUM_DATA_BITS)
    ) u_tx1 (
        .clk(sys_clk), .rst(rst),
        .start(bus.fake_if1_tx_start),
        .data(bus.fake_if1_transmit_data),
        .ready_o(t1_ready), .done_o(bus.if1_tx_write_done),
        .line_o(t1_line)
    );

    // select only follows the request while idle, so a frame never gets cut
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sel0_q <= 1'b0;
            sel1_q <= 1'b0;
        end else begin
            sel0_q <= sel0_d;
            sel1_q <= sel1_d;
        end
    end

    always_comb begin
        sel0_d = t0_ready ? bus.fake_if0_tx_select : sel0_q;
        sel1_d = t1_ready ? bus.fake_if1_tx_select : sel1_q;
    end

    assign bus.if0_tx_write_ready = t0_ready;
    assign bus.if1_tx_write_ready = t1_ready;

    assign if0_tx_out = sel0_q ? t0_line : if1_rx_in;
    assign if1_tx_out = sel1_q ? t1_line : if0_rx_in;
endmodule

// File: tb/tb_uart_controller.sv
// Directed self-checking bench for uart_controller: reset, pass-through,
// RX decode, fake TX timing, busy-start, framing error, glitch, reset abort.
module tb_uart_controller;
    localparam int C = 104;
`ifdef UART_RX_SYNC_EN
    localparam int RX_LAT = 989 + 2;
`else
    localparam int RX_LAT = 989;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rx0, rx1;
    logic tx0, tx1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int nd0_cnt = 0, nd1_cnt = 0, dn0_cnt = 0, dn1_cnt = 0;
    int nd0_cyc = 0, nd1_cyc = 0, dn1_cyc = 0;
    logic dn1_rdy = 1'b0;

    uart_controller_if #(.NUM_DATA_BITS(8)) bus();

    uart_controller dut (
        .sys_clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .if0_rx_in(rx0),
        .if1_rx_in(rx1),
        .if0_tx_out(tx0),
        .if1_tx_out(tx1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.if0_rx_new_data_ready === 1'b1) begin
            nd0_cnt <= nd0_cnt + 1;
            nd0_cyc <= cyc;
        end
        if (bus.if1_rx_new_data_ready === 1'b1) begin
            nd1_cnt <= nd1_cnt + 1;
            nd1_cyc <= cyc;
        end
        if (bus.if0_tx_write_done === 1'b1) dn0_cnt <= dn0_cnt + 1;
        if (bus.if1_tx_write_done === 1'b1) begin
            dn1_cnt <= dn1_cnt + 1;
            dn1_cyc <= cyc;
            dn1_rdy <= bus.if1_tx_write_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // drives one 8N1 frame; the opposite tx_out must mirror it bit-exact
    task automatic send_frame(input int ch, input logic [7:0] d,
                              input logic stop, output int c0);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (ch == 0) rx0 = fr[i];
            else rx1 = fr[i];
            #1;
            if (ch == 0) chk("mirror_tx1", {31'd0, tx1}, {31'd0, fr[i]});
            else chk("mirror_tx0", {31'd0, tx0}, {31'd0, fr[i]});
            repeat (C) @(negedge clk);
        end
        if (ch == 0) rx0 = 1'b1;
        else rx1 = 1'b1;
    endtask

    initial begin
        int c0, t, n0, n1, d0;
        logic [9:0] exp_bits;

        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        bus.fake_if0_tx_select = 1'b0;
        bus.fake_if1_tx_select = 1'b0;
        bus.fake_if0_tx_start = 1'b0;
        bus.fake_if1_tx_start = 1'b0;
        bus.fake_if0_transmit_data = 8'h00;
        bus.fake_if1_transmit_data = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_tx0", {31'd0, tx0}, 32'd1);
        chk("rst_tx1", {31'd0, tx1}, 32'd1);
        chk("rst_rdy0", {31'd0, bus.if0_tx_write_ready}, 32'd1);
        chk("rst_rdy1", {31'd0, bus.if1_tx_write_ready}, 32'd1);
        chk("rst_nd0", {31'd0, bus.if0_rx_new_data_ready}, 32'd0);
        chk("rst_nd1", {31'd0, bus.if1_rx_new_data_ready}, 32'd0);
        chk("rst_dn0", {31'd0, bus.if0_tx_write_done}, 32'd0);
        chk("rst_dn1", {31'd0, bus.if1_tx_write_done}, 32'd0);
        chk("rst_rd0", {24'd0, bus.real_if0_receive_data}, 32'd0);
        chk("rst_rd1", {24'd0, bus.real_if1_receive_data}, 32'd0);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        rx1 = 1'b0;
        #1 chk("pass_tx0_lo", {31'd0, tx0}, 32'd0);
        rx1 = 1'b1;
        #1 chk("pass_tx0_hi", {31'd0, tx0}, 32'd1);

        // RX decode on if0
        n0 = nd0_cnt;
        n1 = nd1_cnt;
        send_frame(0, 8'hA5, 1'b1, c0);
        repeat (20) @(negedge clk);
        chk("rx0_pulses", nd0_cnt - n0, 32'd1);
        chk("rx0_data", {24'd0, bus.real_if0_receive_data}, 32'hA5);
        chk("rx0_cycle", nd0_cyc, c0 + RX_LAT);
        chk("rx1_quiet", nd1_cnt - n1, 32'd0);
        chk("rx1_data0", {24'd0, bus.real_if1_receive_data}, 32'd0);
        chk("tx1_idle", {31'd0, tx1}, 32'd1);

        // fake frame 0x3C on if1 with busy start and select drop mid-frame
        exp_bits = 10'b1_0011_1100_0;
        d0 = dn1_cnt;
        @(negedge clk);
        bus.fake_if1_tx_select = 1'b1;
        bus.fake_if1_transmit_data = 8'h3C;
        bus.fake_if1_tx_start = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.fake_if1_tx_start = 1'b0;
        chk("tx1_busy", {31'd0, bus.if1_tx_write_ready}, 32'd0);
        for (int b = 0; b < 10; b++) begin
            wait_cyc(t + 1 + b * C + C / 2);
            chk("tx1_bit", {31'd0, tx1}, {31'd0, exp_bits[b]});
            if (b == 4) begin
                bus.fake_if1_tx_start = 1'b1;
                bus.fake_if1_transmit_data = 8'hFF;
                bus.fake_if1_tx_select = 1'b0;
                @(negedge clk);
                bus.fake_if1_tx_start = 1'b0;
                chk("tx1_busy2", {31'd0, bus.if1_tx_write_ready}, 32'd0);
            end
        end
        wait_cyc(t + 10 * C + 5);
        chk("tx1_done_cnt", dn1_cnt - d0, 32'd1);
        chk("tx1_done_cyc", dn1_cyc, t + 1 + 10 * C);
        chk("tx1_done_rdy", {31'd0, dn1_rdy}, 32'd1);
        rx0 = 1'b0;
        #1 chk("tx1_pass_lo", {31'd0, tx1}, 32'd0);
        rx0 = 1'b1;
        repeat (200) @(negedge clk);
        chk("tx1_no_second", dn1_cnt - d0, 32'd1);
        chk("tx1_rdy_idle", {31'd0, bus.if1_tx_write_ready}, 32'd1);

        // valid frame, framing error, glitch on if1
        n1 = nd1_cnt;
        send_frame(1, 8'h5A, 1'b1, c0);
        repeat (20) @(negedge clk);
        chk("rx1_pulses", nd1_cnt - n1, 32'd1);
        chk("rx1_data", {24'd0, bus.real_if1_receive_data}, 32'h5A);
        chk("rx1_cycle", nd1_cyc, c0 + RX_LAT);
        n1 = nd1_cnt;
        send_frame(1, 8'hC3, 1'b0, c0);
        repeat (20) @(negedge clk);
        chk("ferr_pulses", nd1_cnt - n1, 32'd0);
        chk("ferr_data", {24'd0, bus.real_if1_receive_data}, 32'h5A);
        rx1 = 1'b0;
        repeat (20) @(negedge clk);
        rx1 = 1'b1;
        repeat (1200) @(negedge clk);
        chk("glitch_pulses", nd1_cnt - n1, 32'd0);
        chk("glitch_data", {24'd0, bus.real_if1_receive_data}, 32'h5A);

        // reset in the middle of a fake frame on if0
        d0 = dn0_cnt;
        @(negedge clk);
        bus.fake_if0_tx_select = 1'b1;
        bus.fake_if0_transmit_data = 8'h00;
        bus.fake_if0_tx_start = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.fake_if0_tx_start = 1'b0;
        wait_cyc(t + 1 + 2 * C + C / 2);
        chk("tx0_data_bit", {31'd0, tx0}, 32'd0);
        rst = 1'b1;
        bus.fake_if0_tx_select = 1'b0;
        #1;
        chk("abort_tx0", {31'd0, tx0}, 32'd1);
        chk("abort_rdy0", {31'd0, bus.if0_tx_write_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx1 = 1'b0;
        #1 chk("abort_pass", {31'd0, tx0}, 32'd0);
        rx1 = 1'b1;
        repeat (1100) @(negedge clk);
        chk("abort_no_done", dn0_cnt - d0, 32'd0);
        chk("abort_rd1", {24'd0, bus.real_if1_receive_data}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
